// File: rtl/muldiv_pkg.sv
// Shared types, constants and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned XLEN = 32;

   // RV32M funct3 encodings
   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [XLEN-1:0] DIV0_QUOT = '1;
   localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic [XLEN-1:0] neg_val(input logic [XLEN-1:0] x);
      return '0 - x;
   endfunction

   function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic is_signed);
      return (is_signed && x[XLEN-1]) ? neg_val(x) : x;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per clock, with a sign fix-up at the end.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN  = muldiv_pkg::XLEN,
   localparam int unsigned CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic            reg_write,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   state_e           state;
   logic [CNT_W-1:0] count;
   op_e              op_q;
   logic             neg_q;
   logic [4:0]       rd_q;
   // hi: multiply upper accumulator / divide partial remainder
   // lo: multiplier shifting out / dividend shifting out, quotient shifting in
   logic [XLEN-1:0]  hi;
   logic [XLEN-1:0]  lo;
   logic [XLEN-1:0]  opb;

   op_e              op_in;
   logic             a_signed;
   logic             b_signed;
   logic             a_neg;
   logic             b_neg;
   logic             neg_in;
   logic             div_zero;
   logic             div_ovf;
   logic [XLEN-1:0]  fast_res;

   logic [XLEN:0]    mul_sum;
   logic [XLEN:0]    div_shift;
   logic [XLEN:0]    div_diff;
   logic [XLEN-1:0]  hi_nxt;
   logic [XLEN-1:0]  lo_nxt;
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]  final_res;

   assign op_in = op_e'(op);

   // Decode the incoming request: operand signedness, result sign and special division cases
   always_comb begin
      a_signed = (op_in == MULH) || (op_in == MULHSU) || (op_in == DIV) || (op_in == REM);
      b_signed = (op_in == MULH) || (op_in == DIV) || (op_in == REM);
      a_neg    = a_signed & rs1_val[XLEN-1];
      b_neg    = b_signed & rs2_val[XLEN-1];
      // quotient sign: operands differ; remainder sign: dividend's
      if (op_in == REM)
         neg_in = a_neg;
      else if (op_in == REMU || op_in == DIVU || op_in == MULHU || op_in == MUL)
         neg_in = 1'b0;
      else
         neg_in = a_neg ^ b_neg;
      div_zero = op[2] && (rs2_val == '0);
      div_ovf  = ((op_in == DIV) || (op_in == REM)) && (rs1_val == INT_MIN) && (rs2_val == '1);
      fast_res = '0;
      if (div_zero)
         fast_res = ((op_in == DIV) || (op_in == DIVU)) ? DIV0_QUOT : rs1_val;
      else if (op_in == DIV)
         fast_res = INT_MIN;
   end

   // One iteration of the shared datapath plus the signed result selected at completion
   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
      div_shift = {hi, lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, opb};
      if (op_q[2]) begin
         if (!div_diff[XLEN]) begin
            hi_nxt = div_diff[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], 1'b1};
         end else begin
            hi_nxt = div_shift[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_nxt = mul_sum[XLEN:1];
         lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
      end
      prod   = {hi_nxt, lo_nxt};
      prod_s = neg_q ? ('0 - prod) : prod;
      final_res = '0;
      case (op_q)
         MUL:                 final_res = prod_s[XLEN-1:0];
         MULH, MULHSU, MULHU: final_res = prod_s[2*XLEN-1:XLEN];
         DIV, DIVU:           final_res = neg_q ? neg_val(lo_nxt) : lo_nxt;
         REM, REMU:           final_res = neg_q ? neg_val(hi_nxt) : hi_nxt;
         default:             final_res = '0;
      endcase
   end

   // Control FSM with registered status outputs, datapath registers and result capture
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= '0;
         op_q      <= MUL;
         neg_q     <= 1'b0;
         rd_q      <= '0;
         hi        <= '0;
         lo        <= '0;
         opb       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         reg_write <= 1'b0;
         result    <= '0;
         rd_out    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q  <= op_in;
                  neg_q <= neg_in;
                  rd_q  <= rd_in;
                  hi    <= '0;
                  lo    <= abs_val(rs1_val, a_signed);
                  opb   <= abs_val(rs2_val, b_signed);
                  count <= '0;
                  busy  <= 1'b1;
                  if (div_zero || div_ovf) begin
                     state     <= DONE;
                     result    <= fast_res;
                     rd_out    <= rd_in;
                     done      <= 1'b1;
                     reg_write <= (rd_in != 5'd0);
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               hi <= hi_nxt;
               lo <= lo_nxt;
               if (count == CNT_W'(XLEN - 1)) begin
                  state     <= DONE;
                  result    <= final_res;
                  rd_out    <= rd_q;
                  done      <= 1'b1;
                  reg_write <= (rd_q != 5'd0);
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            DONE: begin
               state     <= IDLE;
               busy      <= 1'b0;
               done      <= 1'b0;
               reg_write <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               done      <= 1'b0;
               reg_write <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, randomized ops
// against an arithmetic reference model, busy/ignore, reset abort and rd=0.
module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [4:0]  rd_in;
   logic        busy;
   logic        done;
   logic        reg_write;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int checks   = 0;
   int failures = 0;

   muldiv_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .rs1_val   (rs1_val),
      .rs2_val   (rs2_val),
      .rd_in     (rd_in),
      .busy      (busy),
      .done      (done),
      .reg_write (reg_write),
      .result    (result),
      .rd_out    (rd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain 64-bit / integer arithmetic per RV32M rules
   function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      int ia;
      int ib;
      ia = a;
      ib = b;
      case (o)
         3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
         3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
         3'd2: begin p = longint'($signed(a)) * longint'({32'h0, b}); return p[63:32]; end
         3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return ia / ib;
         end
         3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'h0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return ia % ib;
         end
         default: return (b == 32'h0) ? a : a % b;
      endcase
   endfunction

   // Cycles from the accept edge to the edge that raises done
   function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      if (o[2] && (b == 32'h0)) return 0;
      if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return 32;
   endfunction

   // Issue one request and observe its completion (no comparisons here)
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        output int lat, output logic [31:0] res, output logic [4:0] rdo, output logic rw,
                        output logic busy_ok, output logic pulse_one);
      @(negedge clk);
      op = o; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = -1; res = '0; rdo = '0; rw = 1'b0; busy_ok = 1'b1; pulse_one = 1'b0;
      for (int k = 0; k <= 40; k++) begin
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            lat = k; res = result; rdo = rd_out; rw = reg_write;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (lat >= 0) begin
         @(posedge clk);
         #1;
         pulse_one = !done && !busy && !reg_write;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b1; op = 3'd0; rs1_val = 32'd3; rs2_val = 32'd4; rd_in = 5'd7;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL reset_reg_write got=%b exp=0", reg_write); end
      checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
      checks++; if (rd_out !== 5'd0) begin failures++; $display("FAIL reset_rd_out got=%0d exp=0", rd_out); end
      @(negedge clk);
      start = 1'b0; reset = 1'b1;
      @(negedge clk);
   endtask

   typedef struct {
      logic [2:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } dir_t;

   task automatic test_directed();
      dir_t t[$];
      int lat; logic [31:0] res; logic [4:0] rdo; logic rw, bok, p1;
      t.push_back('{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 32});
      t.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32});
      t.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32});
      t.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32});
      t.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32});
      t.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32});
      t.push_back('{3'd5, 32'd100,       32'd7,         32'd14,        32});
      t.push_back('{3'd7, 32'd100,       32'd7,         32'd2,         32});
      t.push_back('{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 0});
      t.push_back('{3'd6, 32'd5,         32'd0,         32'd5,         0});
      t.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0});
      t.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0});
      foreach (t[i]) begin
         do_op(t[i].o, t[i].a, t[i].b, 5'd5, lat, res, rdo, rw, bok, p1);
         checks++; if (lat !== t[i].lat) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, t[i].lat); end
         checks++; if (res !== t[i].exp) begin failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, t[i].exp); end
         checks++; if (rdo !== 5'd5 || rw !== 1'b1) begin failures++; $display("FAIL dir%0d_rd got=%0d/%b exp=5/1", i, rdo, rw); end
         checks++; if (bok !== 1'b1 || p1 !== 1'b1) begin failures++; $display("FAIL dir%0d_handshake busy_ok=%b one_pulse=%b exp=1/1", i, bok, p1); end
      end
   endtask

   task automatic test_random();
      logic [31:0] specials[5];
      logic [31:0] a, b, exp;
      logic [2:0] o;
      logic [4:0] rd;
      int lat; logic [31:0] res; logic [4:0] rdo; logic rw, bok, p1;
      specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'hFFFF_FFFF;
      specials[3] = 32'h8000_0000; specials[4] = 32'h7FFF_FFFF;
      for (int n = 0; n < 48; n++) begin
         o  = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
         rd = 5'($urandom_range(0, 31));
         exp = model_res(o, a, b);
         do_op(o, a, b, rd, lat, res, rdo, rw, bok, p1);
         checks++;
         if (lat !== model_lat(o, a, b) || res !== exp || rdo !== rd || rw !== (rd != 5'd0) || !bok || !p1) begin
            failures++;
            $display("FAIL rand%0d op=%0d a=%h b=%h got res=%h lat=%0d rd=%0d rw=%b exp res=%h lat=%0d rd=%0d rw=%b busy_ok=%b one_pulse=%b",
                     n, o, a, b, res, lat, rdo, rw, exp, model_lat(o, a, b), rd, (rd != 5'd0), bok, p1);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int lat;
      int seen;
      lat = -1; seen = 0;
      @(negedge clk);
      op = 3'd5; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd3; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      op = 3'd0; rs1_val = 32'd3; rs2_val = 32'd3; rd_in = 5'd9; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 10; k <= 40; k++) begin
         if (done) begin lat = k; break; end
         @(posedge clk);
         #1;
      end
      checks++; if (lat !== 32) begin failures++; $display("FAIL busy_ignore_latency got=%0d exp=32", lat); end
      checks++; if (result !== 32'd14) begin failures++; $display("FAIL busy_ignore_result got=%0d exp=14", result); end
      checks++; if (rd_out !== 5'd3) begin failures++; $display("FAIL busy_ignore_rd got=%0d exp=3", rd_out); end
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL busy_ignore_no_second_done got=%0d active cycles exp=0", seen); end
      checks++; if (result !== 32'd14) begin failures++; $display("FAIL busy_ignore_hold got=%0d exp=14", result); end
   endtask

   task automatic test_reset_abort();
      int seen;
      seen = 0;
      @(negedge clk);
      op = 3'd0; rs1_val = 32'd11; rs2_val = 32'd13; rd_in = 5'd4; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
      checks++; if (result !== 32'h0 || rd_out !== 5'd0) begin failures++; $display("FAIL abort_outputs got=%h/%0d exp=0/0", result, rd_out); end
      @(negedge clk);
      reset = 1'b1;
      for (int k = 11; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (done || reg_write) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d pulses exp=0", seen); end
   endtask

   task automatic test_rd_zero();
      int lat; logic [31:0] res; logic [4:0] rdo; logic rw, bok, p1;
      do_op(3'd0, 32'd6, 32'd9, 5'd0, lat, res, rdo, rw, bok, p1);
      checks++; if (lat !== 32 || res !== 32'd54) begin failures++; $display("FAIL rd0_done got lat=%0d res=%0d exp lat=32 res=54", lat, res); end
      checks++; if (rw !== 1'b0 || rdo !== 5'd0) begin failures++; $display("FAIL rd0_reg_write got=%b rd=%0d exp=0 rd=0", rw, rdo); end
      do_op(3'd5, 32'd9, 32'd0, 5'd0, lat, res, rdo, rw, bok, p1);
      checks++; if (lat !== 0 || res !== 32'hFFFF_FFFF || rw !== 1'b0) begin failures++; $display("FAIL rd0_fast got lat=%0d res=%h rw=%b exp lat=0 res=ffffffff rw=0", lat, res, rw); end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; op = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
      test_reset();
      test_directed();
      test_random();
      test_busy_ignore();
      test_reset_abort();
      test_rd_zero();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, sitting directly downstream of Reg_File.
- Consumes read_data1/read_data2 as operands and produces the value and destination index fed back into Reg_File's Write_data/Rd/RegWrite.
- Asserts busy so the single-cycle core can stall PC and writeback while the unit is working.
- Radix-2 shift-add multiply and restoring divide; one bit per clock.

Parameters:
XLEN, 32, operand/result width in bits (iteration count = XLEN)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk; 0 = reset
start  input  1  request pulse; accepted only when busy=0
op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_val  input  XLEN  operand A (from Reg_File read_data1)
rs2_val  input  XLEN  operand B (from Reg_File read_data2)
rd_in  input  5  destination register index
busy  output  1  high from the accept edge until the done cycle completes
done  output  1  one-cycle pulse; result and rd_out valid
reg_write  output  1  equals done; drives Reg_File RegWrite; never high when rd_out=0
result  output  XLEN  computed value
rd_out  output  5  captured rd_in

Behaviour:
- States: IDLE, CALC, DONE.
- busy = (state != IDLE).
- done = reg_write = (state == DONE).
- Reset (reset=0 at an edge): state goes to IDLE, counter 0, all internal registers 0. Outputs become busy=0, done=0, reg_write=0, result=0, rd_out=0. Reset overrides start.
- Reset mid-operation: the operation is aborted; no done pulse is ever produced for it.
- Accept: start=1 in IDLE at edge N. The unit latches op, rd_in, the operand magnitudes and the result sign flags, then moves to CALC with count=0.
- Fast path: if the op is a division and either rs2_val=0 or (rs1_val=0x80000000 and rs2_val=0xFFFFFFFF with op DIV/REM), the unit goes straight to DONE at edge N. done is then high in the cycle after edge N.
- CALC: one iteration per edge. Iterations occur at edges N+1..N+32; when count reaches XLEN-1 the state moves to DONE at edge N+32. done is high for exactly the one cycle following edge N+32, then the state returns to IDLE.
- Multiply: the 2*XLEN unsigned product of magnitudes is negated if the sign flag is set. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits. Signedness per op:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: both operands unsigned.
- Divide: restoring division on magnitudes.
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder takes the dividend's sign.
- Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1_val.
- Overflow case (DIV/REM with rs1=0x80000000, rs2=-1): DIV returns 0x80000000; REM returns 0.
- start while busy (CALC or DONE): ignored. No queuing, and the latched operands are unaffected.
- result and rd_out update only on entry to DONE and hold their value afterwards until the next completion or reset.
- rd_out=0: reg_write is forced to 0, but done still pulses.

Decomposition:
- muldiv_pkg holds:
  - XLEN localparam default.
  - op enum (MUL..REMU, 3-bit).
  - state enum (IDLE, CALC, DONE).
  - functions abs_val and neg_val.
  - constants for the div-by-zero quotient (all ones) and INT_MIN.
- No sub-module is needed. The multiply and divide datapaths share the accumulator/shift registers inside muldiv_unit; a separate module would only add wiring.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), rd=5, start at edge N -> busy high from N; done only in the cycle after N+32; result=0xFFFFFFEB, rd_out=5, reg_write=1 for one cycle.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each has 32-cycle latency.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, with done in the cycle after the accept edge. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- start DIVU 100/7, then pulse start with MUL 3*3 at edge N+10 -> second request ignored; result=14 at N+32; the next done occurs only after a new start in IDLE.
- Drive reset=0 at edge N+10 of a MUL -> at the following edge busy=0, result=0, rd_out=0; no done through N+40. rd=0 operation -> done pulses, reg_write stays 0.
